reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter XLEN, default 64, register data width.
REQ-002 SHALL have parameter NREG, default 32, register count; power of two, 8..64; AW = log2(NREG).
REQ-003 SHALL have parameter SP_IDX, default 2, index loaded with SP_INIT at init.
REQ-004 SHALL have parameter SP_INIT, default 64'h10000, truncated to XLEN.
REQ-005 SHALL have parameter BYPASS, default 1, enables write-to-read forwarding.
REQ-006 CLK  in  1  single clock; all state updates on rising edge.
REQ-007 RST  in  1  reset, synchronous, active-high.
REQ-008 WR0_VALID  in  1  write port 0 enable.
REQ-009 WR0_ADDR  in  AW  write port 0 index.
REQ-010 WR0_DATA  in  XLEN  write port 0 data.
REQ-011 WR1_VALID, WR1_ADDR, WR1_DATA  in  1/AW/XLEN  write port 1, same meaning.
REQ-012 RS1_SEL, RS2_SEL  in  AW  read port indices.
REQ-013 RS1_DATAOUT, RS2_DATAOUT  out  XLEN  combinational read data.
REQ-014 READY  out  1  high once init sequence is complete.

Function
REQ-015 SHALL implement a two-state FSM: INIT, RUN.
REQ-016 In INIT, a counter CNT SHALL write register CNT each cycle: SP_INIT if CNT==SP_IDX, else 0.
REQ-017 CNT SHALL start at 1 and increment by 1 per INIT cycle; at CNT==NREG-1 the write occurs and FSM SHALL move to RUN next edge.
REQ-018 INIT SHALL take exactly NREG-1 cycles (31 at default) after the last cycle RST is high.
REQ-019 READY SHALL be 0 in INIT and 1 in RUN, registered.
REQ-020 In INIT, WR0/WR1 SHALL be ignored and RS1/RS2_DATAOUT SHALL be 0.
REQ-021 In RUN, each port with VALID=1 and ADDR!=0 SHALL write DATA to register ADDR at the edge.
REQ-022 Writes to index 0 SHALL be discarded; reads of index 0 SHALL return 0 in all states.
REQ-023 Both ports valid, same nonzero ADDR: WR1 data SHALL be stored (WR1 priority).
REQ-024 Both ports valid, different ADDR: both SHALL be stored in the same cycle.
REQ-025 BYPASS=1, RUN: RSx_SEL matching a valid nonzero write ADDR SHALL return that write's DATA in the same cycle, WR1 over WR0, over array contents.
REQ-026 BYPASS=0: reads SHALL return array contents only, new value visible the cycle after the write.
REQ-027 Read paths SHALL be purely combinational from RSx_SEL, array, and (if BYPASS) write ports; no read latency.

Reset
REQ-028 RST high at an edge SHALL force FSM=INIT, CNT=1, READY=0, from any state, including mid-INIT.
REQ-029 While RST is held high no register write SHALL occur; the INIT sweep begins on the first edge with RST low.
REQ-030 Register contents are not required to be cleared in the RST cycle; the INIT sweep defines them.

Verification
REQ-031 RST 1 cycle, then idle -> READY=0 for 31 edges, 1 from the 31st; RS1_SEL=2 -> 0x10000; RS1_SEL=5 -> 0.
REQ-032 RUN: WR0 (7, 0xAAAA) and WR1 (9, 0x5555) same cycle -> next cycle RS1_SEL=7 -> 0xAAAA, RS2_SEL=9 -> 0x5555.
REQ-033 RUN: WR0 (4, 0x1111) and WR1 (4, 0x2222) same cycle, RS1_SEL=4 -> 0x2222 same cycle (BYPASS=1) and after.
REQ-034 RUN: WR0 (0, 0xFFFF) -> RS1_SEL=0 reads 0 same cycle and after; bypass does not apply.
REQ-035 Assert RST at INIT cycle 10, hold 2 cycles -> READY stays 0 and rises 31 edges after RST deasserts; WR0 during INIT has no effect.
REQ-036 BYPASS=0, XLEN=32, NREG=16: WR0 (3, 0xDEAD) -> RS1_SEL=3 reads old value that cycle, 0xDEAD next; INIT takes 15 cycles.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with two write ports, two
// combinational read ports and an init sweep that loads known values.
// Index 0 is hard-wired to zero. Index SP_IDX is loaded with SP_INIT during
// init, and every other index is loaded with zero. Forwarding from the write
// ports to the read ports is optional and selected by BYPASS.
module reg_file_mp #(
   parameter int          XLEN    = 64,
   parameter int          NREG    = 32,
   parameter int          SP_IDX  = 2,
   parameter logic [63:0] SP_INIT = 64'h0000_0000_0001_0000,
   parameter bit          BYPASS  = 1'b1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     WR0_VALID,
   input  logic [$clog2(NREG)-1:0]  WR0_ADDR,
   input  logic [XLEN-1:0]          WR0_DATA,
   input  logic                     WR1_VALID,
   input  logic [$clog2(NREG)-1:0]  WR1_ADDR,
   input  logic [XLEN-1:0]          WR1_DATA,
   input  logic [$clog2(NREG)-1:0]  RS1_SEL,
   input  logic [$clog2(NREG)-1:0]  RS2_SEL,
   output logic [XLEN-1:0]          RS1_DATAOUT,
   output logic [XLEN-1:0]          RS2_DATAOUT,
   output logic                     READY
);

   localparam int AW = $clog2(NREG);

   localparam logic [AW-1:0]   IDX_ZERO  = {AW{1'b0}};
   localparam logic [AW-1:0]   CNT_ONE   = AW'(32'd1);
   localparam logic [AW-1:0]   CNT_LAST  = AW'(NREG - 1);
   localparam logic [AW-1:0]   SP_IDX_A  = AW'(SP_IDX);
   localparam logic [XLEN-1:0] SP_INIT_X = SP_INIT[XLEN-1:0];
   localparam logic [XLEN-1:0] DATA_ZERO = {XLEN{1'b0}};

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [AW-1:0]   cnt_r;
   logic [AW-1:0]   cnt_nxt_s;
   logic            ready_r;
   logic            ready_nxt_s;

   logic [XLEN-1:0] regs_r [NREG];

   logic            init_we_s;
   logic [XLEN-1:0] init_data_s;
   logic            wr0_en_s;
   logic            wr1_en_s;
   logic [XLEN-1:0] rs1_data_s;
   logic [XLEN-1:0] rs2_data_s;

   // Next-state, sweep counter and ready flag for the INIT/RUN sequencer.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      ready_nxt_s = ready_r;
      case (state_r)
         ST_INIT: begin
            if (cnt_r == CNT_LAST) begin
               state_nxt_s = ST_RUN;
               ready_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_ONE;
               ready_nxt_s = 1'b0;
            end
         end
         ST_RUN: begin
            ready_nxt_s = 1'b1;
         end
         default: begin
            state_nxt_s = ST_INIT;
            cnt_nxt_s   = CNT_ONE;
            ready_nxt_s = 1'b0;
         end
      endcase
   end

   // Sequencer state register. Reset restarts the sweep from index 1 in any state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= ST_INIT;
         cnt_r   <= CNT_ONE;
         ready_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         ready_r <= ready_nxt_s;
      end
   end

   // Write enables. The init sweep owns the array, and user writes to index 0 are dropped.
   always_comb begin
      init_we_s   = 1'b0;
      init_data_s = DATA_ZERO;
      wr0_en_s    = 1'b0;
      wr1_en_s    = 1'b0;
      if (state_r == ST_INIT) begin
         init_we_s = 1'b1;
         if (cnt_r == SP_IDX_A) begin
            init_data_s = SP_INIT_X;
         end else begin
            init_data_s = DATA_ZERO;
         end
      end else begin
         wr0_en_s = WR0_VALID && (WR0_ADDR != IDX_ZERO);
         wr1_en_s = WR1_VALID && (WR1_ADDR != IDX_ZERO);
      end
   end

   // Register array update. The WR1 assignment comes after WR0, so WR1 wins
   // when both ports write the same index in one cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         regs_r[0] <= DATA_ZERO;
      end else if (init_we_s) begin
         regs_r[cnt_r] <= init_data_s;
      end else begin
         if (wr0_en_s) begin
            regs_r[WR0_ADDR] <= WR0_DATA;
         end
         if (wr1_en_s) begin
            regs_r[WR1_ADDR] <= WR1_DATA;
         end
      end
   end

   // Read port 1 selects zero, then forwarded write data (WR1 before WR0), then the array.
   always_comb begin
      rs1_data_s = DATA_ZERO;
      if ((state_r != ST_RUN) || (RS1_SEL == IDX_ZERO)) begin
         rs1_data_s = DATA_ZERO;
      end else if (BYPASS && wr1_en_s && (WR1_ADDR == RS1_SEL)) begin
         rs1_data_s = WR1_DATA;
      end else if (BYPASS && wr0_en_s && (WR0_ADDR == RS1_SEL)) begin
         rs1_data_s = WR0_DATA;
      end else begin
         rs1_data_s = regs_r[RS1_SEL];
      end
   end

   // Read port 2 uses the same selection order as read port 1.
   always_comb begin
      rs2_data_s = DATA_ZERO;
      if ((state_r != ST_RUN) || (RS2_SEL == IDX_ZERO)) begin
         rs2_data_s = DATA_ZERO;
      end else if (BYPASS && wr1_en_s && (WR1_ADDR == RS2_SEL)) begin
         rs2_data_s = WR1_DATA;
      end else if (BYPASS && wr0_en_s && (WR0_ADDR == RS2_SEL)) begin
         rs2_data_s = WR0_DATA;
      end else begin
         rs2_data_s = regs_r[RS2_SEL];
      end
   end

   assign RS1_DATAOUT = rs1_data_s;
   assign RS2_DATAOUT = rs2_data_s;
   assign READY       = ready_r;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed bench for reg_file_mp. One instance uses the
// default configuration with forwarding. A second instance has XLEN=32,
// NREG=16 and no forwarding. Both instances share the clock and reset.
module tb_reg_file_mp;

   logic        clk;
   logic        rst;

   logic        a_wr0_valid, a_wr1_valid;
   logic [4:0]  a_wr0_addr, a_wr1_addr, a_rs1_sel, a_rs2_sel;
   logic [63:0] a_wr0_data, a_wr1_data, a_rs1_data, a_rs2_data;
   logic        a_ready;

   logic        b_wr0_valid, b_wr1_valid;
   logic [3:0]  b_wr0_addr, b_wr1_addr, b_rs1_sel, b_rs2_sel;
   logic [31:0] b_wr0_data, b_wr1_data, b_rs1_data, b_rs2_data;
   logic        b_ready;

   int checks;
   int failures;

   reg_file_mp u_a (
      .CLK(clk), .RST(rst),
      .WR0_VALID(a_wr0_valid), .WR0_ADDR(a_wr0_addr), .WR0_DATA(a_wr0_data),
      .WR1_VALID(a_wr1_valid), .WR1_ADDR(a_wr1_addr), .WR1_DATA(a_wr1_data),
      .RS1_SEL(a_rs1_sel), .RS2_SEL(a_rs2_sel),
      .RS1_DATAOUT(a_rs1_data), .RS2_DATAOUT(a_rs2_data), .READY(a_ready)
   );

   reg_file_mp #(.XLEN(32), .NREG(16), .BYPASS(1'b0)) u_b (
      .CLK(clk), .RST(rst),
      .WR0_VALID(b_wr0_valid), .WR0_ADDR(b_wr0_addr), .WR0_DATA(b_wr0_data),
      .WR1_VALID(b_wr1_valid), .WR1_ADDR(b_wr1_addr), .WR1_DATA(b_wr1_data),
      .RS1_SEL(b_rs1_sel), .RS2_SEL(b_rs2_sel),
      .RS1_DATAOUT(b_rs1_data), .RS2_DATAOUT(b_rs2_data), .READY(b_ready)
   );

   // 10-time-unit clock with rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Directed sequence: initial sweep, write and forwarding cases,
   // reset during the sweep, then the no-forwarding instance.
   initial begin
      checks      = 0;
      failures    = 0;
      rst         = 1'b1;
      a_wr0_valid = 1'b0; a_wr0_addr = 5'd0; a_wr0_data = 64'd0;
      a_wr1_valid = 1'b0; a_wr1_addr = 5'd0; a_wr1_data = 64'd0;
      a_rs1_sel   = 5'd2; a_rs2_sel  = 5'd0;
      b_wr0_valid = 1'b0; b_wr0_addr = 4'd0; b_wr0_data = 32'd0;
      b_wr1_valid = 1'b0; b_wr1_addr = 4'd0; b_wr1_data = 32'd0;
      b_rs1_sel   = 4'd2; b_rs2_sel  = 4'd0;

      // One reset edge, then the sweep: a finishes after 31 edges, b after 15.
      tick();
      rst = 1'b0;
      check("reset_ready_a", {63'd0, a_ready}, 64'd0);
      for (int i = 1; i <= 31; i++) begin
         tick();
         check("init_ready_a", {63'd0, a_ready}, (i == 31) ? 64'd1 : 64'd0);
         check("init_ready_b", {63'd0, b_ready}, (i >= 15) ? 64'd1 : 64'd0);
         if (i == 10) begin
            check("init_read_zero_a", a_rs1_data, 64'd0);
         end
      end

      // Values loaded by the sweep.
      check("sp_init_a", a_rs1_data, 64'h10000);
      check("sp_init_b", {32'd0, b_rs1_data}, 64'h10000);
      a_rs1_sel = 5'd5;
      #1;
      check("zero_init_a", a_rs1_data, 64'd0);

      // Two ports writing different indices in the same cycle.
      a_wr0_valid = 1'b1; a_wr0_addr = 5'd7; a_wr0_data = 64'hAAAA;
      a_wr1_valid = 1'b1; a_wr1_addr = 5'd9; a_wr1_data = 64'h5555;
      a_rs1_sel = 5'd7; a_rs2_sel = 5'd9;
      #1;
      check("dual_wr_bypass_rs1", a_rs1_data, 64'hAAAA);
      check("dual_wr_bypass_rs2", a_rs2_data, 64'h5555);
      tick();
      a_wr0_valid = 1'b0; a_wr1_valid = 1'b0;
      #1;
      check("dual_wr_rs1", a_rs1_data, 64'hAAAA);
      check("dual_wr_rs2", a_rs2_data, 64'h5555);

      // Both ports write index 4 in the same cycle: WR1 wins, forwarded and stored.
      a_wr0_valid = 1'b1; a_wr0_addr = 5'd4; a_wr0_data = 64'h1111;
      a_wr1_valid = 1'b1; a_wr1_addr = 5'd4; a_wr1_data = 64'h2222;
      a_rs1_sel = 5'd4; a_rs2_sel = 5'd4;
      #1;
      check("same_addr_bypass", a_rs1_data, 64'h2222);
      tick();
      a_wr0_valid = 1'b0; a_wr1_valid = 1'b0;
      #1;
      check("same_addr_stored", a_rs2_data, 64'h2222);

      // Forwarding from WR0 alone, while WR1 writes another index.
      a_wr0_valid = 1'b1; a_wr0_addr = 5'd6; a_wr0_data = 64'h3333;
      a_wr1_valid = 1'b1; a_wr1_addr = 5'd8; a_wr1_data = 64'h4444;
      a_rs1_sel = 5'd6; a_rs2_sel = 5'd7;
      #1;
      check("wr0_bypass", a_rs1_data, 64'h3333);
      check("array_read_no_match", a_rs2_data, 64'hAAAA);
      tick();
      a_wr0_valid = 1'b0; a_wr1_valid = 1'b0;

      // A write to index 0 is neither forwarded nor stored.
      a_wr0_valid = 1'b1; a_wr0_addr = 5'd0; a_wr0_data = 64'hFFFF;
      a_rs1_sel = 5'd0;
      #1;
      check("x0_same_cycle", a_rs1_data, 64'd0);
      tick();
      a_wr0_valid = 1'b0;
      #1;
      check("x0_after", a_rs1_data, 64'd0);

      // No forwarding on b: old value in the write cycle, new value after it.
      b_wr0_valid = 1'b1; b_wr0_addr = 4'd3; b_wr0_data = 32'hDEAD;
      b_rs1_sel = 4'd3;
      #1;
      check("nobyp_old", {32'd0, b_rs1_data}, 64'd0);
      tick();
      b_wr0_valid = 1'b0;
      #1;
      check("nobyp_new", {32'd0, b_rs1_data}, 64'hDEAD);

      // Reset during the sweep. WR0 stays asserted for the whole sweep and
      // must have no effect.
      a_wr0_valid = 1'b1; a_wr0_addr = 5'd7; a_wr0_data = 64'hBEEF;
      a_rs1_sel = 5'd7; a_rs2_sel = 5'd9;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         tick();
         check("reinit_ready_a", {63'd0, a_ready}, 64'd0);
      end
      check("init_wr_no_bypass", a_rs1_data, 64'd0);
      rst = 1'b1;
      tick();
      check("rst_hold1_ready", {63'd0, a_ready}, 64'd0);
      tick();
      check("rst_hold2_ready", {63'd0, a_ready}, 64'd0);
      rst = 1'b0;
      for (int i = 1; i <= 31; i++) begin
         tick();
         check("rerun_ready_a", {63'd0, a_ready}, (i == 31) ? 64'd1 : 64'd0);
         check("rerun_ready_b", {63'd0, b_ready}, (i >= 15) ? 64'd1 : 64'd0);
         if (i == 30) begin
            a_wr0_valid = 1'b0;
         end
      end
      #1;
      check("init_wr_ignored", a_rs1_data, 64'd0);
      check("resweep_clears_9", a_rs2_data, 64'd0);
      a_rs1_sel = 5'd2;
      #1;
      check("resweep_sp", a_rs1_data, 64'h10000);
      check("resweep_b3", {32'd0, b_rs1_data}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
